// File: rtl/blink_scheduler.sv
// blink_scheduler: time-shares one status LED between NREQ requesters.
// Each requester asks for a burst of N blinks, where N comes from its
// cfg_count nibble. A round-robin arbiter picks the next pending requester.
// A prescaled tick then steps an ON/OFF/GAP state machine that plays the
// burst.
// Optional feature: define BLINK_SCHED_ABORT_EN to add an 'abort' input.
// The abort input cuts a burst short and sends it straight to its GAP.
module blink_scheduler #(
   parameter int NREQ      = 4,
   parameter int DIV       = 2500000,
   parameter int ON_TICKS  = 4,
   parameter int OFF_TICKS = 4,
   parameter int GAP_TICKS = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] cfg_count,
`ifdef BLINK_SCHED_ABORT_EN
   input  logic              abort,
`endif
   output logic              led,
   output logic              busy,
   output logic [NREQ-1:0]   grant,
   output logic              done,
   output logic [NREQ-1:0]   pending
);

   // Counter widths. The phase counter must hold the longest state minus one.
   localparam int PRE_W   = $clog2(DIV);
   localparam int MAX_LEN = (ON_TICKS > OFF_TICKS)
                            ? ((ON_TICKS  > GAP_TICKS) ? ON_TICKS  : GAP_TICKS)
                            : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
   localparam int PH_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int PTR_W   = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF,
      S_GAP
   } state_t;

   // Registered state
   state_t            state;
   logic [PRE_W-1:0]  prescaler;
   logic [PH_W-1:0]   phase;
   logic [3:0]        remaining;
   logic [PTR_W-1:0]  ptr;

   // Next-state values
   state_t            state_next;
   logic [PRE_W-1:0]  prescaler_next;
   logic [PH_W-1:0]   phase_next;
   logic [3:0]        remaining_next;
   logic [PTR_W-1:0]  ptr_next;
   logic [NREQ-1:0]   grant_next;
   logic              done_next;
   logic [NREQ-1:0]   claim;

   // Arbiter and tick signals
   logic              found;
   logic [PTR_W-1:0]  winner;
   logic [NREQ-1:0]   win_onehot;
   logic [3:0]        win_count;
   int                scan_idx;
   logic              tick;
   logic [PH_W-1:0]   len_m1;
   logic              phase_last;

   // Round-robin search: first pending bit at or after ptr, wrapping mod NREQ.
   // NOTE: every always_comb output gets a default before any branch; a path
   // that leaves a variable unassigned would infer a latch.
   always_comb begin
      found      = 1'b0;
      winner     = '0;
      win_onehot = '0;
      scan_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = int'(ptr) + k;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         if (!found && pending[scan_idx]) begin
            found  = 1'b1;
            winner = PTR_W'(scan_idx);
         end
      end
      if (found) win_onehot[winner] = 1'b1;
      win_count = cfg_count[4*int'(winner) +: 4];
   end

   // Tick strobe and the current state's length in ticks, minus one.
   always_comb begin
      tick = ena && (prescaler == PRE_W'(DIV - 1));
      case (state)
         S_ON:    len_m1 = PH_W'(ON_TICKS - 1);
         S_OFF:   len_m1 = PH_W'(OFF_TICKS - 1);
         S_GAP:   len_m1 = PH_W'(GAP_TICKS - 1);
         default: len_m1 = '0;
      endcase
      phase_last = (phase == len_m1);
   end

   // Next-state logic: arbitration in IDLE, tick-driven phase stepping elsewhere.
   always_comb begin
      state_next     = state;
      prescaler_next = prescaler;
      phase_next     = phase;
      remaining_next = remaining;
      ptr_next       = ptr;
      grant_next     = grant;
      done_next      = 1'b0;
      claim          = '0;

      case (state)
         S_IDLE: begin
            if (found) begin
               state_next     = S_ON;
               grant_next     = win_onehot;
               claim          = win_onehot;
               remaining_next = (win_count == 4'd0) ? 4'd1 : win_count;
               ptr_next       = (int'(winner) == NREQ - 1) ? '0 : winner + PTR_W'(1);
               prescaler_next = '0;
               phase_next     = '0;
            end
         end
         default: begin
            // The prescaler wraps to 0 on the tick, so it never passes DIV-1.
            if (ena) prescaler_next = tick ? '0 : prescaler + PRE_W'(1);
            if (tick) begin
               if (phase_last) begin
                  phase_next = '0;
                  case (state)
                     S_ON: begin
                        state_next     = S_OFF;
                        remaining_next = remaining - 4'd1;
                     end
                     S_OFF: begin
                        state_next = (remaining != 4'd0) ? S_ON : S_GAP;
                     end
                     S_GAP: begin
                        state_next = S_IDLE;
                        grant_next = '0;
                        done_next  = 1'b1;
                     end
                     default: begin
                        state_next = S_IDLE;
                     end
                  endcase
               end else begin
                  phase_next = phase + PH_W'(1);
               end
            end
`ifdef BLINK_SCHED_ABORT_EN
            // Abort cuts ON/OFF short; a GAP already in progress runs to the end.
            if (abort && (state == S_ON || state == S_OFF)) begin
               state_next     = S_GAP;
               prescaler_next = '0;
               phase_next     = '0;
               remaining_next = '0;
            end
`endif
         end
      endcase
   end

   // State and counter registers. Pending requests use set-wins-over-clear.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         prescaler <= '0;
         phase     <= '0;
         remaining <= '0;
         ptr       <= '0;
         grant     <= '0;
         done      <= 1'b0;
         pending   <= '0;
      end else begin
         state     <= state_next;
         prescaler <= prescaler_next;
         phase     <= phase_next;
         remaining <= remaining_next;
         ptr       <= ptr_next;
         grant     <= grant_next;
         done      <= done_next;
         pending   <= (pending & ~claim) | req;
      end
   end

   // The LED follows the ON state directly; busy is any non-IDLE state.
   always_comb begin
      led  = (state == S_ON);
      busy = (state != S_IDLE);
   end

endmodule
